data_plane_rx: RTL and testbench

//  Receive stage of the data plane; consumes the 32-bit packet stream driven by the tx data plane of a peer node.

---
 rtl/dp_pkg.sv | 23 ++
 rtl/rx_fifo.sv | 79 +++++++
 rtl/data_plane_rx.sv | 191 +++++++++++++++++++
 tb/tb_data_plane_rx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// ---------------------------------------------------------------------------
// dp_pkg: shared constants and types for the data-plane receive stage.
//   PKT_DATA_WORDS : payload words per packet following the header
//   IDLE_PKT       : line value carried when no packet is being sent
//   dp_pkt_t       : one 32-bit line word {dest, body}
//   dp_rx_state_t  : receive FSM states
// ---------------------------------------------------------------------------
package dp_pkg;

  localparam int unsigned PKT_DATA_WORDS = 4;
  localparam logic [31:0] IDLE_PKT       = 32'h0;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] body;
  } dp_pkt_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } dp_rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo: payload storage with speculative write pointer, commit pointer
// and read pointer. Words between commit and write are invisible to the
// reader until committed, or are discarded by a rollback.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_wr_en/data  append one word at the write pointer
//   i_commit      publish everything written so far, including a write
//                 happening on the same edge
//   i_rollback    drop uncommitted words (write pointer back to commit)
//   i_pop         advance the read pointer (ignored when empty)
//   o_rd_data     show-ahead head word, 0 when empty
//   o_empty       no committed words
//   o_level       committed words (commit - rd)
//   o_used        occupied slots including uncommitted (wr - rd)
// ---------------------------------------------------------------------------
module rx_fifo #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUF_DEPTH = 16,
  localparam int unsigned PTR_W    = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_commit,
  input  logic              i_rollback,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic [PTR_W-1:0]  o_level,
  output logic [PTR_W-1:0]  o_used
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_commit_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_wr_ptr_inc;

  assign o_empty      = (r_commit_ptr == r_rd_ptr);
  assign w_pop_ok     = i_pop && !o_empty;
  assign w_wr_ptr_inc = r_wr_ptr + PTR_W'(1);
  assign o_level      = r_commit_ptr - r_rd_ptr;
  assign o_used       = r_wr_ptr - r_rd_ptr;
  assign o_rd_data    = o_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

  // Pointer update; the MSB of each pointer separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (i_rollback) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (i_wr_en) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (i_commit) begin
        r_commit_ptr <= i_wr_en ? w_wr_ptr_inc : r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage array, no reset needed: unread slots are masked by o_empty.
  always_ff @(posedge clk) begin
    if (rst && i_wr_en) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/data_plane_rx.sv
// ---------------------------------------------------------------------------
// data_plane_rx: receive stage of the data plane. Watches the line for a
// header {dest,src} addressed to node_id, then captures PKT_DATA_WORDS
// payload words {dest,data} into rx_fifo and commits them as one unit.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   node_id                this node's id (0 never matches)
//   data_rx_packet         line word, 32'h0 = idle
//   gpp_trf_rx             GPP pop strobe
//   gpp_rx_data            show-ahead head word, 0 when empty
//   rx_empty, rx_level     committed-word status
//   data_rx_complete_flag  1-cycle pulse on packet commit
//   rx_src_node            src id of the last completed packet
//   rx_error_flag          1-cycle pulse on mid-payload abort
//   rx_drop_flag           1-cycle pulse on header refused for lack of space
//   rx_pkt_count           completed packets (stats build only)
//   rx_err_count           aborts + drops (stats build only)
// Build option: define DP_RX_STATS_EN to include the saturating counters;
// otherwise both counter ports read 0.
// ---------------------------------------------------------------------------
module data_plane_rx
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            node_id,
  input  logic [2*DATA_W-1:0]          data_rx_packet,
  input  logic                         gpp_trf_rx,
  output logic [DATA_W-1:0]            gpp_rx_data,
  output logic                         rx_empty,
  output logic [$clog2(BUF_DEPTH):0]   rx_level,
  output logic                         data_rx_complete_flag,
  output logic [DATA_W-1:0]            rx_src_node,
  output logic                         rx_error_flag,
  output logic                         rx_drop_flag,
  output logic [15:0]                  rx_pkt_count,
  output logic [15:0]                  rx_err_count
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(PKT_DATA_WORDS + 1);

  dp_rx_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_src_tmp, w_src_tmp_nxt;
  logic [DATA_W-1:0] r_src_node, w_src_node_nxt;
  logic              r_complete, w_complete_nxt;
  logic              r_error, w_error_nxt;
  logic              r_drop, w_drop_nxt;

  logic [DATA_W-1:0] w_dest;
  logic [DATA_W-1:0] w_body;
  logic              w_dest_match;
  logic              w_is_header;
  logic [PTR_W-1:0]  w_used;
  logic [PTR_W-1:0]  w_free;
  logic              w_has_space;
  logic              w_wr_en;
  logic              w_commit;
  logic              w_rollback;

  assign w_dest       = data_rx_packet[2*DATA_W-1:DATA_W];
  assign w_body       = data_rx_packet[DATA_W-1:0];
  assign w_dest_match = (w_dest == node_id);
  assign w_is_header  = w_dest_match && (node_id != '0);
  // Free space counts uncommitted slots too; in IDLE there are none.
  assign w_free       = PTR_W'(BUF_DEPTH) - w_used;
  assign w_has_space  = (w_free >= PTR_W'(PKT_DATA_WORDS));

  rx_fifo #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_body),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_pop      (gpp_trf_rx),
    .o_rd_data  (gpp_rx_data),
    .o_empty    (rx_empty),
    .o_level    (rx_level),
    .o_used     (w_used)
  );

  // Next-state, FIFO control and flag decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_src_tmp_nxt  = r_src_tmp;
    w_src_node_nxt = r_src_node;
    w_complete_nxt = 1'b0;
    w_error_nxt    = 1'b0;
    w_drop_nxt     = 1'b0;
    w_wr_en        = 1'b0;
    w_commit       = 1'b0;
    w_rollback     = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_is_header) begin
          if (w_has_space) begin
            w_state_nxt   = RX_RECV;
            w_src_tmp_nxt = w_body;
            w_cnt_nxt     = '0;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end
      end
      RX_RECV: begin
        if (w_dest_match) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(PKT_DATA_WORDS - 1)) begin
            w_commit       = 1'b1;
            w_src_node_nxt = r_src_tmp;
            w_complete_nxt = 1'b1;
            w_state_nxt    = RX_IDLE;
            w_cnt_nxt      = '0;
          end
        end else begin
          // Aborting word is consumed here, never re-decoded as a header.
          w_rollback  = 1'b1;
          w_error_nxt = 1'b1;
          w_state_nxt = RX_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // State and registered flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_src_tmp  <= '0;
      r_src_node <= '0;
      r_complete <= 1'b0;
      r_error    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_src_tmp  <= w_src_tmp_nxt;
      r_src_node <= w_src_node_nxt;
      r_complete <= w_complete_nxt;
      r_error    <= w_error_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign data_rx_complete_flag = r_complete;
  assign rx_src_node           = r_src_node;
  assign rx_error_flag         = r_error;
  assign rx_drop_flag          = r_drop;

`ifdef DP_RX_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  // Saturating counters, updated on the same edge as their pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_complete_nxt && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if ((w_error_nxt || w_drop_nxt) && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign rx_pkt_count = r_pkt_count;
  assign rx_err_count = r_err_count;
`else
  assign rx_pkt_count = 16'h0;
  assign rx_err_count = 16'h0;
`endif

endmodule

// File: tb/tb_data_plane_rx.sv
// ---------------------------------------------------------------------------
// tb_data_plane_rx: directed scenarios plus randomized traffic for
// data_plane_rx, checked against a queue-based packet model.
// ---------------------------------------------------------------------------
module tb_data_plane_rx;
  import dp_pkg::*;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BUF_DEPTH = 16;
  localparam logic [15:0] NID       = 16'h0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id;
  logic [31:0] data_rx_packet;
  logic        gpp_trf_rx;
  logic [15:0] gpp_rx_data;
  logic        rx_empty;
  logic [4:0]  rx_level;
  logic        data_rx_complete_flag;
  logic [15:0] rx_src_node;
  logic        rx_error_flag;
  logic        rx_drop_flag;
  logic [15:0] rx_pkt_count;
  logic [15:0] rx_err_count;

  always #5 clk = ~clk;

  data_plane_rx #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .data_rx_packet        (data_rx_packet),
    .gpp_trf_rx            (gpp_trf_rx),
    .gpp_rx_data           (gpp_rx_data),
    .rx_empty              (rx_empty),
    .rx_level              (rx_level),
    .data_rx_complete_flag (data_rx_complete_flag),
    .rx_src_node           (rx_src_node),
    .rx_error_flag         (rx_error_flag),
    .rx_drop_flag          (rx_drop_flag),
    .rx_pkt_count          (rx_pkt_count),
    .rx_err_count          (rx_err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed words, pending packet words, packet state.
  logic [15:0] q_c[$];
  logic [15:0] q_p[$];
  bit          m_in_pkt;
  logic [15:0] m_src_tmp;
  logic [15:0] m_src;
  logic        e_complete, e_error, e_drop;
  int          m_pkt_cnt, m_err_cnt;

  function automatic logic [31:0] mk(input logic [15:0] d, input logic [15:0] b);
    dp_pkt_t p;
    p.dest = d;
    p.body = b;
    return p;
  endfunction

  function automatic logic [15:0] exp_head();
    return (q_c.size() != 0) ? q_c[0] : 16'h0;
  endfunction

  function automatic logic [15:0] exp_pkt_cnt();
`ifdef DP_RX_STATS_EN
    return 16'(m_pkt_cnt);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_err_cnt();
`ifdef DP_RX_STATS_EN
    return 16'(m_err_cnt);
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    q_c.delete();
    q_p.delete();
    m_in_pkt   = 1'b0;
    m_src_tmp  = '0;
    m_src      = '0;
    e_complete = 1'b0;
    e_error    = 1'b0;
    e_drop     = 1'b0;
    m_pkt_cnt  = 0;
    m_err_cnt  = 0;
  endtask

  // One line cycle: drive on negedge, apply packet rules to the model at
  // the posedge, return 1 time unit after the edge for sampling.
  task automatic step(input logic [31:0] w, input bit pop);
    logic [15:0] dest, body;
    bit          do_pop;
    @(negedge clk);
    data_rx_packet = w;
    gpp_trf_rx     = pop;
    @(posedge clk);
    dest       = w[31:16];
    body       = w[15:0];
    do_pop     = pop && (q_c.size() != 0);
    e_complete = 1'b0;
    e_error    = 1'b0;
    e_drop     = 1'b0;
    if (!m_in_pkt) begin
      if (dest == node_id && node_id != 16'h0) begin
        if (int'(BUF_DEPTH) - q_c.size() >= int'(PKT_DATA_WORDS)) begin
          m_in_pkt  = 1'b1;
          m_src_tmp = body;
          q_p.delete();
        end else begin
          e_drop = 1'b1;
        end
      end
    end else if (dest == node_id) begin
      q_p.push_back(body);
      if (q_p.size() == int'(PKT_DATA_WORDS)) begin
        foreach (q_p[i]) q_c.push_back(q_p[i]);
        q_p.delete();
        m_src      = m_src_tmp;
        e_complete = 1'b1;
        m_in_pkt   = 1'b0;
      end
    end else begin
      q_p.delete();
      e_error  = 1'b1;
      m_in_pkt = 1'b0;
    end
    if (do_pop) void'(q_c.pop_front());
    if (e_complete && m_pkt_cnt < 65535) m_pkt_cnt++;
    if ((e_error || e_drop) && m_err_cnt < 65535) m_err_cnt++;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst            = 1'b0;
    data_rx_packet = 32'h0;
    gpp_trf_rx     = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    @(negedge clk);
    rst        = 1'b1;
    gpp_trf_rx = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (rx_empty !== 1'b1 || rx_level !== 5'd0 || gpp_rx_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_fifo: empty=%b level=%0d data=%h, want 1/0/0000", rx_empty, rx_level, gpp_rx_data);
    end
    n_tests++;
    if ({data_rx_complete_flag, rx_error_flag, rx_drop_flag} !== 3'b000 || rx_src_node !== 16'h0 ||
        rx_pkt_count !== 16'h0 || rx_err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flags: c/e/d=%b%b%b src=%h pk=%0d er=%0d, want all 0",
               data_rx_complete_flag, rx_error_flag, rx_drop_flag, rx_src_node, rx_pkt_count, rx_err_count);
    end
  endtask

  task automatic test_basic_packet();
    step(mk(NID, 16'h0009), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(mk(NID, 16'hAAA1 + 16'(i)), 1'b0);
      n_tests++;
      if (data_rx_complete_flag !== 1'b0 || rx_level !== 5'd0) begin
        n_fail++;
        $display("FAIL basic_early word%0d: complete=%b level=%0d, want 0/0", i, data_rx_complete_flag, rx_level);
      end
    end
    step(mk(NID, 16'hAAA4), 1'b0);
    n_tests++;
    if (data_rx_complete_flag !== 1'b1 || rx_src_node !== 16'h0009 || rx_level !== 5'd4 ||
        rx_pkt_count !== exp_pkt_cnt()) begin
      n_fail++;
      $display("FAIL basic_commit: complete=%b src=%h level=%0d pk=%0d, want 1/0009/4/%0d",
               data_rx_complete_flag, rx_src_node, rx_level, rx_pkt_count, exp_pkt_cnt());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (gpp_rx_data !== 16'hAAA1 + 16'(i)) begin
        n_fail++;
        $display("FAIL basic_pop%0d: data=%h want %h", i, gpp_rx_data, 16'hAAA1 + 16'(i));
      end
      step(32'h0, 1'b1);
      if (i == 0) begin
        n_tests++;
        if (data_rx_complete_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_pulse_width: complete=%b want 0", data_rx_complete_flag);
        end
      end
    end
    n_tests++;
    if (rx_empty !== 1'b1 || gpp_rx_data !== 16'h0 || rx_src_node !== 16'h0009) begin
      n_fail++;
      $display("FAIL basic_drained: empty=%b data=%h src=%h, want 1/0000/0009", rx_empty, gpp_rx_data, rx_src_node);
    end
    step(32'h0, 1'b1);
    n_tests++;
    if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: level=%0d empty=%b, want 0/1", rx_level, rx_empty);
    end
  endtask

  task automatic test_foreign_and_idle();
    step(mk(16'h0007, 16'h0001), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(16'h0007, 16'hBEE0 + 16'(i)), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(32'h0, 1'b0);
      n_tests++;
      if ({data_rx_complete_flag, rx_error_flag, rx_drop_flag} !== 3'b000 || rx_level !== 5'd0) begin
        n_fail++;
        $display("FAIL foreign_idle%0d: c/e/d=%b%b%b level=%0d, want 000/0",
                 i, data_rx_complete_flag, rx_error_flag, rx_drop_flag, rx_level);
      end
    end
  endtask

  task automatic test_abort();
    step(mk(NID, 16'h0003), 1'b0);
    step(mk(NID, 16'hD001), 1'b0);
    step(mk(NID, 16'hD002), 1'b0);
    step(32'h0, 1'b0);
    n_tests++;
    if (rx_error_flag !== 1'b1 || rx_level !== 5'd0 || rx_err_count !== exp_err_cnt()) begin
      n_fail++;
      $display("FAIL abort: error=%b level=%0d er=%0d, want 1/0/%0d", rx_error_flag, rx_level, rx_err_count, exp_err_cnt());
    end
    step(mk(NID, 16'h0004), 1'b0);
    n_tests++;
    if (rx_error_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse_width: error=%b want 0", rx_error_flag);
    end
    for (int i = 0; i < 4; i++) step(mk(NID, 16'hE001 + 16'(i)), 1'b0);
    n_tests++;
    if (data_rx_complete_flag !== 1'b1 || rx_level !== 5'd4 || rx_src_node !== 16'h0004 || gpp_rx_data !== 16'hE001) begin
      n_fail++;
      $display("FAIL abort_recover: complete=%b level=%0d src=%h head=%h, want 1/4/0004/E001",
               data_rx_complete_flag, rx_level, rx_src_node, gpp_rx_data);
    end
    for (int i = 0; i < 4; i++) step(32'h0, 1'b1);
  endtask

  task automatic test_drop();
    for (int p = 0; p < 4; p++) begin
      step(mk(NID, 16'h0010 + 16'(p)), 1'b0);
      for (int i = 0; i < 4; i++) step(mk(NID, 16'(p * 16 + i)), 1'b0);
    end
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    n_tests++;
    if (rx_level !== 5'd14) begin
      n_fail++;
      $display("FAIL drop_fill: level=%0d want 14", rx_level);
    end
    step(mk(NID, 16'h0020), 1'b0);
    n_tests++;
    if (rx_drop_flag !== 1'b1 || rx_level !== 5'd14 || rx_err_count !== exp_err_cnt()) begin
      n_fail++;
      $display("FAIL drop: drop=%b level=%0d er=%0d, want 1/14/%0d", rx_drop_flag, rx_level, rx_err_count, exp_err_cnt());
    end
    step(32'h0, 1'b1);
    n_tests++;
    if (rx_drop_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse_width: drop=%b want 0", rx_drop_flag);
    end
    step(32'h0, 1'b1);
    step(mk(NID, 16'h0021), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(NID, 16'hF001 + 16'(i)), 1'b0);
    n_tests++;
    if (data_rx_complete_flag !== 1'b1 || rx_level !== 5'd16 || rx_drop_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_resend: complete=%b level=%0d drop=%b, want 1/16/0", data_rx_complete_flag, rx_level, rx_drop_flag);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (gpp_rx_data !== exp_head()) begin
        n_fail++;
        $display("FAIL drop_drain%0d: data=%h want %h", i, gpp_rx_data, exp_head());
      end
      step(32'h0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_seq [7];
    exp_seq = '{16'hB002, 16'hB003, 16'hB004, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
    step(mk(NID, 16'h0001), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(NID, 16'hB001 + 16'(i)), 1'b0);
    step(mk(NID, 16'h0002), 1'b1);
    n_tests++;
    if (rx_level !== 5'd3 || gpp_rx_data !== 16'hB002) begin
      n_fail++;
      $display("FAIL b2b_first: level=%0d head=%h, want 3/B002", rx_level, gpp_rx_data);
    end
    for (int i = 0; i < 4; i++) step(mk(NID, 16'hC001 + 16'(i)), 1'b0);
    n_tests++;
    if (rx_level !== 5'd7 || data_rx_complete_flag !== 1'b1 || rx_src_node !== 16'h0002) begin
      n_fail++;
      $display("FAIL b2b_second: level=%0d complete=%b src=%h, want 7/1/0002", rx_level, data_rx_complete_flag, rx_src_node);
    end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (gpp_rx_data !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL b2b_order%0d: data=%h want %h", i, gpp_rx_data, exp_seq[i]);
      end
      step(32'h0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_packet();
    step(mk(NID, 16'h0033), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(NID, 16'h1000 + 16'(i)), 1'b0);
    step(mk(NID, 16'h0034), 1'b0);
    step(mk(NID, 16'h2000), 1'b0);
    step(mk(NID, 16'h2001), 1'b0);
    apply_reset();
    n_tests++;
    if (rx_empty !== 1'b1 || rx_level !== 5'd0 || gpp_rx_data !== 16'h0 || rx_src_node !== 16'h0 ||
        rx_pkt_count !== 16'h0 || rx_err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: empty=%b level=%0d data=%h src=%h pk=%0d er=%0d, want 1/0/0/0/0/0",
               rx_empty, rx_level, gpp_rx_data, rx_src_node, rx_pkt_count, rx_err_count);
    end
    step(mk(NID, 16'h0035), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(NID, 16'h3000 + 16'(i)), 1'b0);
    n_tests++;
    if (rx_level !== 5'd4 || data_rx_complete_flag !== 1'b1 || gpp_rx_data !== 16'h3000 || rx_pkt_count !== exp_pkt_cnt()) begin
      n_fail++;
      $display("FAIL reset_mid_after: level=%0d complete=%b head=%h pk=%0d, want 4/1/3000/%0d",
               rx_level, data_rx_complete_flag, gpp_rx_data, rx_pkt_count, exp_pkt_cnt());
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          r;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      w = 32'h0;
      else if (r < 18) w = mk(16'($urandom_range(6, 9)), 16'($urandom));
      else             w = mk(NID, 16'($urandom));
      step(w, ($urandom_range(0, 99) < 45));
      n_tests++;
      if (rx_level !== 5'(q_c.size()) || rx_empty !== (q_c.size() == 0) || gpp_rx_data !== exp_head() ||
          data_rx_complete_flag !== e_complete || rx_error_flag !== e_error || rx_drop_flag !== e_drop ||
          rx_src_node !== m_src || rx_pkt_count !== exp_pkt_cnt() || rx_err_count !== exp_err_cnt()) begin
        n_fail++;
        $display("FAIL random%0d: lvl=%0d/%0d data=%h/%h c=%b/%b e=%b/%b d=%b/%b src=%h/%h pk=%0d/%0d er=%0d/%0d (got/want)",
                 n, rx_level, q_c.size(), gpp_rx_data, exp_head(), data_rx_complete_flag, e_complete,
                 rx_error_flag, e_error, rx_drop_flag, e_drop, rx_src_node, m_src,
                 rx_pkt_count, exp_pkt_cnt(), rx_err_count, exp_err_cnt());
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    node_id        = NID;
    data_rx_packet = 32'h0;
    gpp_trf_rx     = 1'b0;
    model_reset();
    test_reset();
    test_basic_packet();
    test_foreign_and_idle();
    test_abort();
    test_drop();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
